// File: rtl/pkarr_pkg.sv
// pkarr_pkg -- shared types and defaults for the packed-array access controller.
//   Default geometry: 4 requesters, 6 entries of 4 bits, 3-bit addresses.
//   entry_t / store_t describe one entry and the whole packed store.
//   idx_width() gives the requester-index width used for ptr / rid.
package pkarr_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int N_ENT_DEF = 6;
  localparam int W_DEF     = 4;
  localparam int AW_DEF    = 3;

  typedef logic [W_DEF-1:0]           entry_t;
  typedef entry_t [N_ENT_DEF-1:0]     store_t;

  // Entry 0 resets to 1, all other entries to 0.
  localparam logic [N_ENT_DEF*W_DEF-1:0] RST_VAL_DEF = 24'h000001;

  // Width of an index into n requesters; never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pkarr_rr_arb.sv
// pkarr_rr_arb -- combinational round-robin arbiter.
//   req     in   N_REQ   request vector
//   ptr     in   IW      highest-priority requester this cycle
//   gnt     out  N_REQ   one-hot grant (zero when no request)
//   gnt_idx out  IW      encoded index of the granted requester
//   gnt_vld out  1       any grant issued
module pkarr_rr_arb
  import pkarr_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]                 req,
  input  logic [idx_width(N_REQ)-1:0]      ptr,
  output logic [N_REQ-1:0]                 gnt,
  output logic [idx_width(N_REQ)-1:0]      gnt_idx,
  output logic                             gnt_vld
);

  localparam int IW = idx_width(N_REQ);

  logic found;

  // Walk the requesters starting at ptr and take the first one asserting req.
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      int unsigned idx;
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IW'(idx);
      end
    end
  end

  assign gnt_vld = found;

endmodule

// File: rtl/pkarr_access_ctrl.sv
// pkarr_access_ctrl -- round-robin access controller for a packed register store.
//   One access is granted per cycle. Writes commit on the grant edge; reads
//   return one cycle later tagged with the requester index. Out-of-range
//   addresses pulse err, drop writes and return zero on reads.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req/we             per-requester request and write-enable
//   addr/wdata         per-requester address and write data (flattened)
//   gnt                one-hot combinational grant
//   rvalid/rid/rdata   registered read response
//   err                one-cycle out-of-range pulse
//   store_q            whole store, flat packed vector
// Optional: define PKARR_ASSERT_EN to compile in immediate assertions.
module pkarr_access_ctrl
  import pkarr_pkg::*;
#(
  parameter int                    N_REQ   = N_REQ_DEF,
  parameter int                    N_ENT   = N_ENT_DEF,
  parameter int                    W       = W_DEF,
  parameter int                    AW      = AW_DEF,
  parameter logic [N_ENT*W-1:0]    RST_VAL = RST_VAL_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0]              we,
  input  logic [N_REQ*AW-1:0]           addr,
  input  logic [N_REQ*W-1:0]            wdata,
  output logic [N_REQ-1:0]              gnt,
  output logic                          rvalid,
  output logic [idx_width(N_REQ)-1:0]   rid,
  output logic [W-1:0]                  rdata,
  output logic                          err,
  output logic [N_ENT*W-1:0]            store_q
);

  localparam int IW = idx_width(N_REQ);

  logic [N_ENT-1:0][W-1:0] store_r;
  logic [IW-1:0]           ptr;
  logic [IW-1:0]           gnt_idx;
  logic                    gnt_vld;

  logic [AW-1:0]           addr_g;
  logic [W-1:0]            wdata_g;
  logic                    we_g;
  logic                    in_range;
  logic                    wr_en;
  logic [W-1:0]            rd_entry;

  pkarr_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Fields of the granted requester.
  assign addr_g   = addr[int'(gnt_idx)*AW +: AW];
  assign wdata_g  = wdata[int'(gnt_idx)*W +: W];
  assign we_g     = we[gnt_idx];
  assign in_range = (32'(addr_g) < 32'(N_ENT));
  assign wr_en    = gnt_vld && we_g && in_range;

  // Compare-based read mux so an address beyond N_ENT never indexes the store.
  always_comb begin
    rd_entry = '0;
    for (int e = 0; e < N_ENT; e++) begin
      if (32'(addr_g) == 32'(e)) rd_entry = store_r[e];
    end
  end

  // NOTE: the store is a small register array, not a RAM macro, so it is
  // reset to RST_VAL together with the rest of the state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_r <= RST_VAL;
      ptr     <= '0;
      rvalid  <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      err    <= gnt_vld && !in_range;
      rvalid <= gnt_vld && !we_g;
      if (gnt_vld) begin
        ptr <= (32'(gnt_idx) == 32'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        if (!we_g) begin
          rid   <= gnt_idx;
          rdata <= in_range ? rd_entry : '0;
        end
      end
      for (int e = 0; e < N_ENT; e++) begin
        if (wr_en && 32'(addr_g) == 32'(e)) store_r[e] <= wdata_g;
      end
`ifdef PKARR_ASSERT_EN
      assert (!(wr_en && !in_range))
        else $error("write committed to out-of-range address %0d", addr_g);
`endif
    end
  end

  assign store_q = store_r;

`ifdef PKARR_ASSERT_EN
  always @* begin
    assert ($onehot0(gnt)) else $error("gnt not one-hot: %b", gnt);
    assert ((gnt & ~req) == '0) else $error("gnt %b without req %b", gnt, req);
  end

  if ($bits(RST_VAL) != N_ENT * W) begin : g_bad_rst_val
    $error("RST_VAL width %0d does not match N_ENT*W", $bits(RST_VAL));
  end
`endif

endmodule

// File: tb/tb_pkarr_access_ctrl.sv
// tb_pkarr_access_ctrl -- scoreboard bench for pkarr_access_ctrl.
//   A behavioural model (integer array store + round-robin pointer) predicts
//   each cycle's grant, read response, err and store image. Predictions go
//   into queues; a monitor on the falling edge pops and compares.
module tb_pkarr_access_ctrl;

  localparam int N_REQ = 4;
  localparam int N_ENT = 6;
  localparam int W     = 4;
  localparam int AW    = 3;
  localparam logic [23:0] RST_IMG = 24'h000001;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N_REQ-1:0]      req;
  logic [N_REQ-1:0]      we;
  logic [N_REQ*AW-1:0]   addr;
  logic [N_REQ*W-1:0]    wdata;
  logic [N_REQ-1:0]      gnt;
  logic                  rvalid;
  logic [1:0]            rid;
  logic [W-1:0]          rdata;
  logic                  err;
  logic [N_ENT*W-1:0]    store_q;

  pkarr_access_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .gnt     (gnt),
    .rvalid  (rvalid),
    .rid     (rid),
    .rdata   (rdata),
    .err     (err),
    .store_q (store_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rv;
    bit          er;
    logic [23:0] img;
  } cyc_t;

  typedef struct {
    int rid;
    int data;
  } rd_t;

  cyc_t cyc_q[$];
  rd_t  rd_q[$];

  int   total = 0;
  int   bad   = 0;
  int   m_store[N_ENT];
  int   m_ptr;
  bit   mon_en = 1'b0;
  logic [N_REQ-1:0] last_gnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] model_img();
    logic [23:0] v;
    v = '0;
    for (int e = 0; e < N_ENT; e++) v[e*W +: W] = m_store[e][W-1:0];
    return v;
  endfunction

  function automatic void model_reset();
    for (int e = 0; e < N_ENT; e++) m_store[e] = 0;
    m_store[0] = 1;
    m_ptr = 0;
  endfunction

  function automatic logic [N_REQ*AW-1:0] pa(input int slot, input int v);
    logic [N_REQ*AW-1:0] r;
    r = '0;
    r[slot*AW +: AW] = AW'(v);
    return r;
  endfunction

  function automatic logic [N_REQ*W-1:0] pd(input int slot, input int v);
    logic [N_REQ*W-1:0] r;
    r = '0;
    r[slot*W +: W] = W'(v);
    return r;
  endfunction

  // Drive one cycle of stimulus, check the combinational grant and queue
  // the predicted registered response. Returns the granted index or -1.
  task automatic step(input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] w,
                      input logic [N_REQ*AW-1:0] a, input logic [N_REQ*W-1:0] d,
                      output int g);
    cyc_t e;
    int   ad;
    bit   ok;
    @(negedge clk);
    req = r; we = w; addr = a; wdata = d;
    #1;
    g = -1;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (m_ptr + k) % N_REQ;
      if (g < 0 && r[idx]) g = idx;
    end
    check("gnt", 64'(gnt), (g < 0) ? 64'd0 : (64'd1 << g));
    last_gnt = gnt;
    e.rv = 1'b0;
    e.er = 1'b0;
    if (g >= 0) begin
      ad   = int'(a[g*AW +: AW]);
      ok   = (ad < N_ENT);
      e.er = !ok;
      if (w[g]) begin
        if (ok) m_store[ad] = int'(d[g*W +: W]);
      end else begin
        e.rv = 1'b1;
        rd_q.push_back('{rid: g, data: ok ? m_store[ad] : 0});
      end
      m_ptr = (g + 1) % N_REQ;
    end
    e.img = model_img();
    cyc_q.push_back(e);
  endtask

  // Monitor: outputs are registered, so they are stable on the falling edge.
  initial begin
    cyc_t e;
    rd_t  rr;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (cyc_q.size() > 0) begin
          e = cyc_q.pop_front();
          check("rvalid", 64'(rvalid), 64'(e.rv));
          check("err", 64'(err), 64'(e.er));
          check("store_q", 64'(store_q), 64'(e.img));
        end
        if (rvalid) begin
          if (rd_q.size() == 0) begin
            check("unexpected_rvalid", 64'(rvalid), 64'd0);
          end else begin
            rr = rd_q.pop_front();
            check("rid", 64'(rid), 64'(rr.rid));
            check("rdata", 64'(rdata), 64'(rr.data));
          end
        end
      end
    end
  end

  initial begin
    int g;
    int cnt[N_REQ];
    logic [N_REQ-1:0]    pend;
    logic [N_REQ-1:0]    pwe;
    logic [N_REQ*AW-1:0] pad;
    logic [N_REQ*W-1:0]  pdt;

    // Reset; gnt follows req even while reset is held.
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    model_reset();
    #12;
    check("reset_store_q", 64'(store_q), 64'(RST_IMG));
    check("reset_rvalid", 64'(rvalid), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    check("reset_gnt", 64'(gnt), 64'd0);
    check("reset_rid_rdata", 64'({rid, rdata}), 64'd0);
    req = 4'b0100;
    #1;
    check("reset_gnt_follows_req", 64'(gnt), 64'b0100);
    req = '0;
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Requester 2 writes addr 3 = A, then reads it back.
    step(4'b0100, 4'b0100, pa(2, 3), pd(2, 4'hA), g);
    step(4'b0100, 4'b0000, pa(2, 3), '0, g);

    // Out-of-range write and read by requester 1.
    step(4'b0010, 4'b0010, pa(1, 6), pd(1, 4'hF), g);
    step(4'b0010, 4'b0000, pa(1, 7), '0, g);

    // Write in T by requester 0, read of the same entry in T+1 by requester 3.
    step(4'b0001, 4'b0001, pa(0, 5), pd(0, 4'h7), g);
    step(4'b1000, 4'b0000, pa(3, 5), '0, g);

    // Randomized traffic; each request is held until granted.
    pend = '0; pwe = '0; pad = '0; pdt = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!pend[i] && ($urandom_range(1, 0) != 0)) begin
          pend[i]          = 1'b1;
          pwe[i]           = 1'($urandom_range(1, 0));
          pad[i*AW +: AW]  = AW'($urandom_range(7, 0));
          pdt[i*W +: W]    = W'($urandom);
        end
      end
      step(pend, pwe, pad, pdt, g);
      if (g >= 0) pend[g] = 1'b0;
    end
    step('0, '0, '0, '0, g);

    // Read granted, then reset pulsed before the next edge.
    step(4'b0100, 4'b0000, pa(2, 0), '0, g);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    req = '0;
    check("read_before_reset_rvalid", 64'(rvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_rvalid", 64'(rvalid), 64'd0);
    check("midreset_store_q", 64'(store_q), 64'(RST_IMG));
    rst_n = 1'b1;
    cyc_q.delete();
    rd_q.delete();
    model_reset();
    @(negedge clk);
    mon_en = 1'b1;

    // Fairness from ptr=0: all requesters read continuously.
    for (int i = 0; i < N_REQ; i++) cnt[i] = 0;
    for (int c = 0; c < 2 * N_REQ; c++) begin
      step(4'b1111, 4'b0000, pa(0, 1) | pa(1, 2) | pa(2, 3) | pa(3, 4), '0, g);
      for (int i = 0; i < N_REQ; i++) if (last_gnt[i]) cnt[i]++;
      if (c == 0) check("first_gnt_after_reset", 64'(last_gnt), 64'b0001);
    end
    for (int i = 0; i < N_REQ; i++) check("fair_count", 64'(cnt[i]), 64'd2);

    // Drain.
    step('0, '0, '0, '0, g);
    step('0, '0, '0, '0, g);
    @(negedge clk);
    #1;
    check("cyc_queue_drained", 64'(cyc_q.size()), 64'd0);
    check("rd_queue_drained", 64'(rd_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
